ps2_keys: RTL and testbench
===========================

PS2_KEYS -- requirements
Module: ps2_keys

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the number of clk cycles without a PS/2 falling edge after which a partial frame is aborted.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-006 w_press, s_press, a_press, d_press, space_press, enter_press  output  1 each  level; 1 while the key is held, 0 when released.
REQ-007 scan_code  output  8  last accepted data byte.
REQ-008 code_valid  output  1  one-cycle pulse when scan_code updates.
REQ-009 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-010 ps2_clk and ps2_data SHALL pass through 2-flop synchronizers, and a falling edge SHALL be detected on the synchronized ps2_clk.
REQ-011 Each falling edge SHALL sample one frame bit: start (0), 8 data bits LSB first, odd parity, stop (1).
REQ-012 Receiver states: IDLE, DATA (bit counter 0..7), PARITY, STOP; IDLE leaves only on a sampled start bit of 0, and a sampled 1 in IDLE is ignored.
REQ-013 If the stop bit is 1 and the 9 bits (data + parity) contain an odd number of ones, scan_code SHALL load the byte and code_valid SHALL pulse on the clk cycle after the stop-bit edge.
REQ-014 A bad parity or a stop bit of 0 SHALL pulse frame_err instead of code_valid and discard the byte.
REQ-015 In any state other than IDLE, TIMEOUT_CYCLES clk cycles without a falling edge SHALL return the receiver to IDLE and pulse frame_err; the counter clears on every edge.
REQ-016 Decoder FSM states: D_IDLE, D_BREAK (after 0xF0), D_EXT (after 0xE0), D_EXTBRK (after 0xE0 0xF0).
REQ-017 In D_IDLE, byte 0xF0 SHALL move to D_BREAK, 0xE0 to D_EXT, and any other byte is a make code that sets its mapped output to 1.
REQ-018 In D_BREAK, the byte SHALL clear its mapped output to 0 and the decoder SHALL return to D_IDLE.
REQ-019 In D_EXT, 0xF0 SHALL move to D_EXTBRK and any other byte returns to D_IDLE; in D_EXTBRK, any byte returns to D_IDLE.
REQ-020 Key map: 0x1D->w, 0x1B->s, 0x1C->a, 0x23->d, 0x29->space, 0x5A->enter; unmapped codes change no output but still step the FSM.
REQ-021 Press outputs SHALL update on the same cycle code_valid pulses (total latency: one clk after the stop-bit edge is detected).
REQ-022 A frame_err SHALL force the decoder to D_IDLE and SHALL leave all press outputs unchanged.
REQ-023 A repeated make code for a held key (typematic) SHALL keep its output at 1 and produce no glitch.

Reset
REQ-024 While rst=0: all press outputs, scan_code, code_valid and frame_err SHALL be 0; receiver in IDLE; decoder in D_IDLE; timeout counter 0; synchronizer flops 1 (bus idle high).
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, reception restarts at the next start bit.

Configuration
REQ-026 With KEY_ARROW_EN defined, extended codes SHALL also map: 0xE0 0x75 (up)->w, 0xE0 0x72 (down)->s, 0xE0 0x6B (left)->a, 0xE0 0x74 (right)->d; make codes in D_EXT and break codes in D_EXTBRK act on the same outputs as the plain keys.
REQ-027 Without KEY_ARROW_EN, extended sequences SHALL step the FSM only and never change a press output.

Structure
REQ-028 Package ps2_pkg SHALL hold the scan-code constants (0xF0, 0xE0, the key codes and the arrow codes), the receiver and decoder state encodings, and the TIMEOUT_CYCLES default.
REQ-029 Frame reception (REQ-010..015) SHALL be the sub-module ps2_rx, which outputs byte, valid and err; ps2_keys SHALL instantiate it and hold the decoder FSM.

Verification
REQ-030 Frame 0x1D (parity 1) -> one code_valid, scan_code=0x1D, w_press=1; then 0xF0, 0x1D -> w_press=0, two code_valid pulses.
REQ-031 Frame 0x5A with the parity bit inverted -> frame_err pulse, no code_valid, enter_press stays 0.
REQ-032 Start bit and 4 data bits, then idle for TIMEOUT_CYCLES+1 -> frame_err pulse, receiver IDLE; the next full frame 0x29 -> space_press=1.
REQ-033 0x1B, 0x1B, 0x1B (typematic) -> s_press rises once and stays 1; 0xF0, 0x1B -> 0.
REQ-034 0xE0, 0x75 -> w_press=1 with KEY_ARROW_EN defined, 0 without it; 0xE0, 0xF0, 0x75 -> w_press=0.
REQ-035 rst=0 asserted in the middle of the data bits of 0x23 -> all outputs 0; after release, a full 0x23 frame -> d_press=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 keyboard shared definitions: scan codes, receiver/decoder state
// encodings, key index map and the default frame timeout.
package ps2_pkg;

  localparam int TIMEOUT_DEFAULT = 50000;

  // Prefix and key scan codes (set 2)
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions in the press vector
  localparam int NUM_KEYS  = 6;
  localparam int KEY_W     = 0;
  localparam int KEY_S     = 1;
  localparam int KEY_A     = 2;
  localparam int KEY_D     = 3;
  localparam int KEY_SPACE = 4;
  localparam int KEY_ENTER = 5;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_BREAK, D_EXT, D_EXTBRK} dec_state_t;

  // One-hot press mask for a plain scan code (zero when unmapped)
  function automatic logic [NUM_KEYS-1:0] key_map(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      SC_W:     m[KEY_W]     = 1'b1;
      SC_S:     m[KEY_S]     = 1'b1;
      SC_A:     m[KEY_A]     = 1'b1;
      SC_D:     m[KEY_D]     = 1'b1;
      SC_SPACE: m[KEY_SPACE] = 1'b1;
      SC_ENTER: m[KEY_ENTER] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  // One-hot press mask for the code following an E0 prefix
  function automatic logic [NUM_KEYS-1:0] arrow_map(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      SC_UP:    m[KEY_W] = 1'b1;
      SC_DOWN:  m[KEY_S] = 1'b1;
      SC_LEFT:  m[KEY_A] = 1'b1;
      SC_RIGHT: m[KEY_D] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw bus, samples one bit per
// falling ps2_clk edge and checks start/parity/stop. valid/err are
// single-cycle strobes in the cycle the stop edge (or timeout) is seen;
// rx_byte holds the assembled data byte while valid is high.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       valid,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  sync_clk_q, sync_clk_d;
  logic [1:0]  sync_dat_q, sync_dat_d;
  logic        clk_prev_q, clk_prev_d;
  rx_state_t   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic fall;
  logic din;

  assign din     = sync_dat_q[1];
  assign fall    = clk_prev_q & ~sync_clk_q[1];
  assign rx_byte = shift_q;

  // Synchronizers, edge history and frame state; bus idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_clk_q <= 2'b11;
      sync_dat_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      sync_clk_q <= sync_clk_d;
      sync_dat_q <= sync_dat_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Bit sampling, frame checks and the inter-edge timeout
  always_comb begin
    sync_clk_d = {sync_clk_q[0], ps2_clk};
    sync_dat_d = {sync_dat_q[0], ps2_data};
    clk_prev_d = sync_clk_q[1];
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    valid      = 1'b0;
    err        = 1'b0;

    if (state_q == RX_IDLE || fall) to_cnt_d = '0;
    else                            to_cnt_d = to_cnt_q + 1'b1;

    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          // a sampled 1 here is noise or a stray edge; wait for a real start
          if (!din) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = din;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (din && (^{shift_q, par_q})) valid = 1'b1;
          else                            err   = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      err      = 1'b1;
      state_d  = RX_IDLE;
      to_cnt_d = '0;
    end
  end

endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard front end: frame receiver plus make/break decoder that
// tracks WASD, space and enter as held-key levels.
// Optional: KEY_ARROW_EN maps the extended arrow keys onto w/s/a/d.
module ps2_keys
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w_press,
  output logic       s_press,
  output logic       a_press,
  output logic       d_press,
  output logic       space_press,
  output logic       enter_press,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .valid    (rx_valid),
    .err      (rx_err)
  );

  dec_state_t          dec_q, dec_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [7:0]          scan_code_q, scan_code_d;
  logic                code_valid_q, code_valid_d;
  logic                frame_err_q, frame_err_d;

  // Decoder state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q        <= D_IDLE;
      keys_q       <= '0;
      scan_code_q  <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      dec_q        <= dec_d;
      keys_q       <= keys_d;
      scan_code_q  <= scan_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Make/break decode; press levels move in the same cycle as code_valid
  always_comb begin
    dec_d        = dec_q;
    keys_d       = keys_q;
    scan_code_d  = scan_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (rx_err) begin
      // a broken frame may have eaten a prefix; resync without touching keys
      frame_err_d = 1'b1;
      dec_d       = D_IDLE;
    end else if (rx_valid) begin
      code_valid_d = 1'b1;
      scan_code_d  = rx_byte;
      case (dec_q)
        D_IDLE: begin
          if (rx_byte == SC_BREAK)    dec_d = D_BREAK;
          else if (rx_byte == SC_EXT) dec_d = D_EXT;
          else                        keys_d = keys_q | key_map(rx_byte);
        end
        D_BREAK: begin
          keys_d = keys_q & ~key_map(rx_byte);
          dec_d  = D_IDLE;
        end
        D_EXT: begin
          if (rx_byte == SC_BREAK) begin
            dec_d = D_EXTBRK;
          end else begin
`ifdef KEY_ARROW_EN
            keys_d = keys_q | arrow_map(rx_byte);
`endif
            dec_d = D_IDLE;
          end
        end
        D_EXTBRK: begin
`ifdef KEY_ARROW_EN
          keys_d = keys_q & ~arrow_map(rx_byte);
`endif
          dec_d = D_IDLE;
        end
        default: dec_d = D_IDLE;
      endcase
    end
  end

  assign w_press     = keys_q[KEY_W];
  assign s_press     = keys_q[KEY_S];
  assign a_press     = keys_q[KEY_A];
  assign d_press     = keys_q[KEY_D];
  assign space_press = keys_q[KEY_SPACE];
  assign enter_press = keys_q[KEY_ENTER];
  assign scan_code   = scan_code_q;
  assign code_valid  = code_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keys.sv
// Directed bench for ps2_keys: a frame table with expected pulse counts,
// scan code and press vector, plus hand sequences for timeout and reset.
module tb_ps2_keys;

  localparam int TO   = 300;
  localparam int HALF = 10;
`ifdef KEY_ARROW_EN
  localparam bit ARROW = 1'b1;
`else
  localparam bit ARROW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic w_press, s_press, a_press, d_press, space_press, enter_press;
  logic [7:0] scan_code;
  logic code_valid, frame_err;

  ps2_keys #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .w_press(w_press), .s_press(s_press), .a_press(a_press), .d_press(d_press),
    .space_press(space_press), .enter_press(enter_press),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cv_cnt = 0;
  int er_cnt = 0;
  always @(negedge clk) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err)  er_cnt <= er_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    int         cv;
    int         er;
    logic [7:0] scan;
    logic [5:0] keys;   // {enter,space,d,a,s,w}
  } vec_t;
  vec_t tbl[$];

  function automatic logic [5:0] keys_now();
    return {enter_press, space_press, d_press, a_press, s_press, w_press};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input bit bp, input bit bs,
                     input int cv, input int er, input logic [7:0] sc, input logic [5:0] k);
    tbl.push_back('{c, bp, bs, cv, er, sc, k});
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bp, input bit bs);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit((~^c) ^ bp);
    send_bit(~bs);
    ps2_data = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int cv0, er0;
    logic [5:0] arw;
    arw = ARROW ? 6'b000001 : 6'b000000;

    // make/break basics, bad parity, typematic, extended, mapping, stop error
    add(8'h1D, 0, 0, 1, 0, 8'h1D, 6'b000001);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, 6'b000001);
    add(8'h1D, 0, 0, 1, 0, 8'h1D, 6'b000000);
    add(8'h5A, 1, 0, 0, 1, 8'h1D, 6'b000000);
    add(8'h1B, 0, 0, 1, 0, 8'h1B, 6'b000010);
    add(8'h1B, 0, 0, 1, 0, 8'h1B, 6'b000010);
    add(8'h1B, 0, 0, 1, 0, 8'h1B, 6'b000010);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, 6'b000010);
    add(8'h1B, 0, 0, 1, 0, 8'h1B, 6'b000000);
    add(8'hE0, 0, 0, 1, 0, 8'hE0, 6'b000000);
    add(8'h75, 0, 0, 1, 0, 8'h75, arw);
    add(8'hE0, 0, 0, 1, 0, 8'hE0, arw);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, arw);
    add(8'h75, 0, 0, 1, 0, 8'h75, 6'b000000);
    add(8'h5A, 0, 0, 1, 0, 8'h5A, 6'b100000);
    add(8'h1C, 0, 0, 1, 0, 8'h1C, 6'b100100);
    add(8'h77, 0, 0, 1, 0, 8'h77, 6'b100100);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, 6'b100100);
    add(8'h5A, 0, 0, 1, 0, 8'h5A, 6'b000100);
    add(8'h23, 0, 1, 0, 1, 8'h5A, 6'b000100);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, 6'b000100);
    add(8'h1C, 1, 0, 0, 1, 8'hF0, 6'b000100);
    add(8'h23, 0, 0, 1, 0, 8'h23, 6'b001100);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, 6'b001100);
    add(8'h1C, 0, 0, 1, 0, 8'h1C, 6'b001000);
    add(8'hF0, 0, 0, 1, 0, 8'hF0, 6'b001000);
    add(8'h23, 0, 0, 1, 0, 8'h23, 6'b000000);

    // reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_keys", 32'(keys_now()), 32'h0);
    chk("rst_scan", 32'(scan_code), 32'h0);
    chk("rst_cv",   32'(code_valid), 32'h0);
    chk("rst_err",  32'(frame_err), 32'h0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      cv0 = cv_cnt; er0 = er_cnt;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
      @(negedge clk);
      chk($sformatf("v%0d_cv", i),   32'(cv_cnt - cv0), 32'(tbl[i].cv));
      chk($sformatf("v%0d_err", i),  32'(er_cnt - er0), 32'(tbl[i].er));
      chk($sformatf("v%0d_scan", i), 32'(scan_code), 32'(tbl[i].scan));
      chk($sformatf("v%0d_keys", i), 32'(keys_now()), 32'(tbl[i].keys));
    end

    // idle bus for a long time: no timeout outside a frame
    er0 = er_cnt;
    repeat (TO + 20) @(posedge clk);
    @(negedge clk);
    chk("idle_no_err", 32'(er_cnt - er0), 32'h0);

    // partial frame then silence: timeout error, then a clean frame works
    cv0 = cv_cnt; er0 = er_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 10) @(posedge clk);
    @(negedge clk);
    chk("to_err", 32'(er_cnt - er0), 32'h1);
    chk("to_cv",  32'(cv_cnt - cv0), 32'h0);
    cv0 = cv_cnt;
    send_frame(8'h29, 0, 0);
    @(negedge clk);
    chk("to_next_cv",    32'(cv_cnt - cv0), 32'h1);
    chk("to_next_space", 32'(space_press), 32'h1);
    chk("to_next_scan",  32'(scan_code), 32'h29);

    // reset in the middle of the data bits of 0x23
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    ps2_data = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_keys", 32'(keys_now()), 32'h0);
    chk("mid_rst_scan", 32'(scan_code), 32'h0);
    chk("mid_rst_cv",   32'(code_valid), 32'h0);
    chk("mid_rst_err",  32'(frame_err), 32'h0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    cv0 = cv_cnt; er0 = er_cnt;
    send_frame(8'h23, 0, 0);
    @(negedge clk);
    chk("post_rst_cv",   32'(cv_cnt - cv0), 32'h1);
    chk("post_rst_err",  32'(er_cnt - er0), 32'h0);
    chk("post_rst_d",    32'(keys_now()), 32'h08);
    chk("post_rst_scan", 32'(scan_code), 32'h23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
